// File: rtl/score_board.sv
// ============================================================================
// score_board : BCD score counter with per-frame shadow and 3x5 glyph renderer
// Rev 1.0
// ============================================================================
`default_nettype none

module score_board #(
  parameter int         DIGITS       = 2,
  parameter int         POSX         = 100,
  parameter int         POSY         = 16,
  parameter int         GLYPH_W      = 12,
  parameter int         GLYPH_H      = 20,
  parameter int         GAP          = 4,
  parameter int         WIN_SCORE    = 11,
  parameter int         BLINK_FRAMES = 30,
  parameter logic [2:0] FG_RGB       = 3'b111
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  point,
  input  logic                  clear,
  input  logic                  frame_tick,
  input  logic [9:0]            row,
  input  logic [9:0]            col,
  output logic [2:0]            rgb,
  output logic                  active,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic                  win
);

  function automatic logic [4*DIGITS-1:0] f_to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int                  t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Glyph rows packed top row first; MSB of each row is the leftmost cell.
  function automatic logic f_font(input logic [3:0] d, input logic [2:0] y,
                                  input logic [1:0] x);
    logic [14:0] g;
    logic [2:0]  r;
    case (d)
      4'd0:    g = 15'b111_101_101_101_111;
      4'd1:    g = 15'b001_001_001_001_001;
      4'd2:    g = 15'b111_001_111_100_111;
      4'd3:    g = 15'b111_001_111_001_111;
      4'd4:    g = 15'b101_101_111_001_001;
      4'd5:    g = 15'b111_100_111_001_111;
      4'd6:    g = 15'b111_100_111_101_111;
      4'd7:    g = 15'b111_001_001_001_001;
      4'd8:    g = 15'b111_101_111_101_111;
      4'd9:    g = 15'b111_101_111_001_111;
      default: g = 15'b0;
    endcase
    case (y)
      3'd0:    r = g[14:12];
      3'd1:    r = g[11:9];
      3'd2:    r = g[8:6];
      3'd3:    r = g[5:3];
      3'd4:    r = g[2:0];
      default: r = 3'b000;
    endcase
    case (x)
      2'd0:    return r[2];
      2'd1:    return r[1];
      2'd2:    return r[0];
      default: return 1'b0;
    endcase
  endfunction

  localparam int c_PITCH = GLYPH_W + GAP;
  localparam int c_CW    = GLYPH_W / 3;
  localparam int c_CH    = GLYPH_H / 5;
  localparam int c_XEND  = POSX + DIGITS * c_PITCH - GAP - 1;
  localparam int c_YEND  = POSY + GLYPH_H - 1;
  localparam int c_DW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int c_BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [4*DIGITS-1:0] c_WIN_BCD = f_to_bcd(WIN_SCORE);

  logic [4*DIGITS-1:0] r_score;
  logic [4*DIGITS-1:0] r_shadow;
  logic                r_win;
  logic [c_BW-1:0]     r_blink_cnt;
  logic                r_blink_hide;
  logic [4*DIGITS-1:0] w_inc;
  logic [DIGITS-1:0]   w_carry;
  logic [DIGITS-1:0]   w_blank;

  assign w_carry[0] = 1'b1;

  // Ripple BCD increment; w_blank[i] is true when digit i and everything above it is zero.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] w_nib;
      logic [3:0] w_snib;
      assign w_nib  = r_score[4*gi +: 4];
      assign w_snib = r_shadow[4*gi +: 4];
      assign w_inc[4*gi +: 4] = w_carry[gi] ? ((w_nib == 4'd9) ? 4'd0 : w_nib + 4'd1) : w_nib;
      if (gi < DIGITS - 1) begin : g_cy
        assign w_carry[gi+1] = w_carry[gi] & (w_nib == 4'd9);
      end
      if (gi == 0) begin : g_lsd
        assign w_blank[gi] = 1'b0;
      end else if (gi == DIGITS - 1) begin : g_msd
        assign w_blank[gi] = (w_snib == 4'd0);
      end else begin : g_mid
        assign w_blank[gi] = (w_snib == 4'd0) & w_blank[gi+1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_score <= '0;
      r_win   <= 1'b0;
    end else if (clear) begin
      r_score <= '0;
      r_win   <= 1'b0;
    end else if (point && !r_win) begin
      r_score <= w_inc;
      r_win   <= (w_inc == c_WIN_BCD);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow <= '0;
    end else if (frame_tick) begin
      r_shadow <= r_score;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_cnt  <= '0;
      r_blink_hide <= 1'b0;
    end else if (clear || !r_win) begin
      r_blink_cnt  <= '0;
      r_blink_hide <= 1'b0;
    end else if (frame_tick) begin
      if (r_blink_cnt == c_BW'(BLINK_FRAMES - 1)) begin
        r_blink_cnt  <= '0;
        r_blink_hide <= ~r_blink_hide;
      end else begin
        r_blink_cnt  <= r_blink_cnt + 1'b1;
      end
    end
  end

  // Stage 1: geometry decode of the incoming pixel coordinate.
  logic [11:0]     w_cx;
  logic [11:0]     w_cy;
  logic [11:0]     w_off;
  logic            w_area;
  logic            r_s1_area;
  logic            r_s1_gap;
  logic [c_DW-1:0] r_s1_dig;
  logic [1:0]      r_s1_fx;
  logic [2:0]      r_s1_fy;

  assign w_cx   = {2'b00, col} - 12'(POSX);
  assign w_cy   = {2'b00, row} - 12'(POSY);
  assign w_off  = w_cx % 12'(c_PITCH);
  assign w_area = ({2'b00, col} >= 12'(POSX)) && ({2'b00, col} <= 12'(c_XEND)) &&
                  ({2'b00, row} >= 12'(POSY)) && ({2'b00, row} <= 12'(c_YEND));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_area <= 1'b0;
      r_s1_gap  <= 1'b0;
      r_s1_dig  <= '0;
      r_s1_fx   <= '0;
      r_s1_fy   <= '0;
    end else begin
      r_s1_area <= w_area;
      r_s1_gap  <= (w_off >= 12'(GLYPH_W));
      r_s1_dig  <= c_DW'(DIGITS - 1) - c_DW'(w_cx / 12'(c_PITCH));
      r_s1_fx   <= 2'(w_off / 12'(c_CW));
      r_s1_fy   <= 3'(w_cy / 12'(c_CH));
    end
  end

  // Stage 2: font lookup against the shadow digit.
  logic [3:0] w_nib_sel;
  logic       w_blank_sel;
  logic       w_lit;
  logic       r_active;
  logic [2:0] r_rgb;

  always_comb begin
    w_nib_sel   = 4'd0;
    w_blank_sel = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_s1_dig == c_DW'(i)) begin
        w_nib_sel   = r_shadow[4*i +: 4];
        w_blank_sel = w_blank[i];
      end
    end
    w_lit = r_s1_area & ~r_s1_gap & f_font(w_nib_sel, r_s1_fy, r_s1_fx) &
            ~w_blank_sel & ~r_blink_hide;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_active <= 1'b0;
      r_rgb    <= 3'b000;
    end else begin
      r_active <= w_lit;
      r_rgb    <= w_lit ? FG_RGB : 3'b000;
    end
  end

  assign score_bcd = r_score;
  assign win       = r_win;
  assign active    = r_active;
  assign rgb       = r_rgb;

endmodule

`default_nettype wire
